jesd_lmfc_gen: RTL and testbench

- Generates the JESD204B/C local multiframe clock (LMFC) phase in the coreclk domain.
- Aligns the LMFC phase to a SYSREF input, with programmable delay.
- Supports three SYSREF modes: disabled (free-run), one-shot, continuous.
- Monitors SYSREF phase error with a saturating error counter.
- Sits beside the JESD clock buffer block. It feeds the LMFC edge and counter to the link TX/RX framers and to the deterministic-latency logic.

---
 rtl/jesd_pkg.sv | 19 +
 rtl/jesd_sysref_capture.sv | 73 +++++++
 rtl/jesd_lmfc_gen.sv | 112 +++++++++++
 tb/tb_jesd_lmfc_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/jesd_pkg.sv
// Shared encodings for the LMFC generator: FSM states and SYSREF mode values.
package jesd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_ALIGNED = 2'd2
    } lmfc_state_e;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd1;
    localparam logic [1:0] MODE_CONT    = 2'd2;

    // The reserved encoding behaves exactly like MODE_OFF.
    function automatic logic mode_is_off(input logic [1:0] mode);
        return !((mode == MODE_ONESHOT) || (mode == MODE_CONT));
    endfunction

endpackage

// File: rtl/jesd_sysref_capture.sv
// SYSREF rising-edge detector followed by a programmable delay; emits a registered
// one-cycle align_evt pulse. The latest edge restarts any pending count.
module jesd_sysref_capture #(
    parameter int DLY_W = 4
) (
    input  logic             coreclk,
    input  logic             reset,
    input  logic             sysref,
    input  logic             cancel,
    input  logic [DLY_W-1:0] cfg_delay,
    output logic             align_evt
);

    localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);

    logic             sysref_r_q, sysref_r_d;
    logic             sysref_r2_q, sysref_r2_d;
    logic             busy_q, busy_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             evt_q, evt_d;
    logic             sysref_edge;
    logic             fire;

    always_comb begin
        sysref_r_d  = sysref;
        sysref_r2_d = sysref_r_q;
        sysref_edge = sysref_r_q & ~sysref_r2_q;
        busy_d      = busy_q;
        dly_d       = dly_q;
        fire        = 1'b0;
        // dly_q holds the cycles still to wait; the event fires in the cycle it is 0.
        if (sysref_edge) begin
            if (cfg_delay == '0) begin
                fire   = 1'b1;
                busy_d = 1'b0;
            end else begin
                busy_d = 1'b1;
                dly_d  = cfg_delay - DLY_ONE;
            end
        end else if (busy_q) begin
            if (dly_q == '0) begin
                fire   = 1'b1;
                busy_d = 1'b0;
            end else begin
                dly_d = dly_q - DLY_ONE;
            end
        end
        if (cancel) begin
            busy_d = 1'b0;
            fire   = 1'b0;
        end
        evt_d = fire;
    end

    always_ff @(posedge coreclk) begin
        if (reset) begin
            sysref_r_q  <= 1'b0;
            sysref_r2_q <= 1'b0;
            busy_q      <= 1'b0;
            dly_q       <= '0;
            evt_q       <= 1'b0;
        end else begin
            sysref_r_q  <= sysref_r_d;
            sysref_r2_q <= sysref_r2_d;
            busy_q      <= busy_d;
            dly_q       <= dly_d;
            evt_q       <= evt_d;
        end
    end

    assign align_evt = evt_q;

endmodule

// File: rtl/jesd_lmfc_gen.sv
// JESD204B/C LMFC phase generator: free-running multiframe beat counter that is
// aligned to SYSREF, with a three-state alignment FSM and SYSREF phase monitoring.
module jesd_lmfc_gen
    import jesd_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4,
    parameter int OCT_W           = 10,
    parameter int DLY_W           = 4,
    parameter int ERR_CNT_W       = 8
) (
    input  logic                 coreclk,
    input  logic                 reset,
    input  logic [OCT_W-1:0]     cfg_octets_per_mf,
    input  logic [1:0]           cfg_sysref_mode,
    input  logic [DLY_W-1:0]     cfg_sysref_delay,
    input  logic                 sysref,
    input  logic                 re_arm,
    output logic                 lmfc_edge,
    output logic [OCT_W-1:0]     lmfc_counter,
    output logic                 aligned,
    output logic [1:0]           state,
    output logic                 sysref_err,
    output logic [ERR_CNT_W-1:0] sysref_err_cnt
);

    localparam int                   BEAT_SHIFT = $clog2(DATA_PATH_WIDTH);
    localparam logic [OCT_W-1:0]     OCT_ONE    = OCT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE    = ERR_CNT_W'(1);

    lmfc_state_e          state_q, state_d;
    logic [OCT_W-1:0]     cnt_q, cnt_d;
    logic                 edge_q, edge_d;
    logic                 aligned_q, aligned_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [OCT_W-1:0]     beats;
    logic [OCT_W-1:0]     last_beat;
    logic [OCT_W-1:0]     nat_next;
    logic                 mode_off;
    logic                 align_evt;
    logic                 evt_live;
    logic                 realign;
    logic                 mismatch;

    jesd_sysref_capture #(
        .DLY_W(DLY_W)
    ) u_capture (
        .coreclk   (coreclk),
        .reset     (reset),
        .sysref    (sysref),
        .cancel    (mode_off),
        .cfg_delay (cfg_sysref_delay),
        .align_evt (align_evt)
    );

    always_comb begin
        beats     = cfg_octets_per_mf >> BEAT_SHIFT;
        last_beat = (beats == '0) ? '0 : beats - OCT_ONE;
        // >= so that shrinking the multiframe at runtime wraps immediately.
        nat_next  = (cnt_q >= last_beat) ? '0 : cnt_q + OCT_ONE;
        mode_off  = mode_is_off(cfg_sysref_mode);
        evt_live  = align_evt & ~mode_off;
        realign   = evt_live & ((state_q == ST_ARMED) ||
                    ((state_q == ST_ALIGNED) && (cfg_sysref_mode == MODE_CONT)));
        mismatch  = evt_live & (state_q == ST_ALIGNED) & (nat_next != '0);

        cnt_d     = realign ? '0 : nat_next;
        edge_d    = (cnt_d == '0);
        err_d     = mismatch;
        err_cnt_d = (mismatch && (err_cnt_q != '1)) ? err_cnt_q + ERR_ONE : err_cnt_q;

        state_d = state_q;
        if (mode_off) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:    state_d = ST_ARMED;
                ST_ARMED:   if (align_evt) state_d = ST_ALIGNED;
                ST_ALIGNED: if (re_arm) state_d = ST_ARMED;
                default:    state_d = ST_IDLE;
            endcase
        end
        aligned_d = (state_d == ST_ALIGNED);
    end

    always_ff @(posedge coreclk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            edge_q    <= 1'b0;
            aligned_q <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            aligned_q <= aligned_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign lmfc_edge      = edge_q;
    assign lmfc_counter   = cnt_q;
    assign aligned        = aligned_q;
    assign state          = state_q;
    assign sysref_err     = err_q;
    assign sysref_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_jesd_lmfc_gen.sv
// Directed bench for jesd_lmfc_gen: a table of free-run/config vectors followed by
// hand-timed SYSREF sequences (one-shot, continuous, saturation, resize, reset).
module tb_jesd_lmfc_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] cfg_octets_per_mf;
    logic [1:0] cfg_sysref_mode;
    logic [3:0] cfg_sysref_delay;
    logic       sysref;
    logic       re_arm;
    logic       lmfc_edge;
    logic [9:0] lmfc_counter;
    logic       aligned;
    logic [1:0] state;
    logic       sysref_err;
    logic [1:0] sysref_err_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [9:0] octets;
        logic [1:0] mode;
        int         n;
        logic [9:0] exp_cnt;
        logic       exp_edge;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[11];

    jesd_lmfc_gen #(
        .DATA_PATH_WIDTH(4),
        .OCT_W(10),
        .DLY_W(4),
        .ERR_CNT_W(2)
    ) dut (
        .coreclk           (clk),
        .reset             (reset),
        .cfg_octets_per_mf (cfg_octets_per_mf),
        .cfg_sysref_mode   (cfg_sysref_mode),
        .cfg_sysref_delay  (cfg_sysref_delay),
        .sysref            (sysref),
        .re_arm            (re_arm),
        .lmfc_edge         (lmfc_edge),
        .lmfc_counter      (lmfc_counter),
        .aligned           (aligned),
        .state             (state),
        .sysref_err        (sysref_err),
        .sysref_err_cnt    (sysref_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic sysref_at(input int t);
        run_to(t);
        sysref = 1'b1;
        tick();
        sysref = 1'b0;
    endtask

    task automatic start(input logic [9:0] oct, input logic [1:0] mode, input logic [3:0] dly);
        reset             = 1'b1;
        sysref            = 1'b0;
        re_arm            = 1'b0;
        cfg_octets_per_mf = oct;
        cfg_sysref_mode   = mode;
        cfg_sysref_delay  = dly;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int cnt, input logic edg, input int st);
        check({tag, " counter"}, 32'(lmfc_counter), 32'(cnt));
        check({tag, " edge"}, 32'(lmfc_edge), 32'(edg));
        check({tag, " state"}, 32'(state), 32'(st));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // octets, mode, cycles after reset release, expected counter/edge/state
        vecs[0]  = '{10'd32,   2'd0, 5,   10'd5,  1'b0, 2'd0};
        vecs[1]  = '{10'd32,   2'd0, 8,   10'd0,  1'b1, 2'd0};
        vecs[2]  = '{10'd32,   2'd0, 15,  10'd7,  1'b0, 2'd0};
        vecs[3]  = '{10'd16,   2'd0, 6,   10'd2,  1'b0, 2'd0};
        vecs[4]  = '{10'd2,    2'd0, 1,   10'd0,  1'b1, 2'd0};
        vecs[5]  = '{10'd2,    2'd0, 7,   10'd0,  1'b1, 2'd0};
        vecs[6]  = '{10'd0,    2'd0, 3,   10'd0,  1'b1, 2'd0};
        vecs[7]  = '{10'd1023, 2'd0, 300, 10'd45, 1'b0, 2'd0};
        vecs[8]  = '{10'd32,   2'd1, 4,   10'd4,  1'b0, 2'd1};
        vecs[9]  = '{10'd32,   2'd3, 4,   10'd4,  1'b0, 2'd0};
        vecs[10] = '{10'd36,   2'd2, 9,   10'd0,  1'b1, 2'd1};

        // Reset values
        start(10'd32, 2'd0, 4'd0);
        check_out("reset", 0, 1'b0, 0);
        check("reset aligned", 32'(aligned), 32'd0);
        check("reset err", 32'(sysref_err), 32'd0);
        check("reset err_cnt", 32'(sysref_err_cnt), 32'd0);

        // Free-run and config table
        for (int i = 0; i < 11; i++) begin
            start(vecs[i].octets, vecs[i].mode, 4'd0);
            run_to(vecs[i].n);
            check_out($sformatf("vec%0d", i), int'(vecs[i].exp_cnt), vecs[i].exp_edge,
                      int'(vecs[i].exp_state));
        end

        // One-shot: delay 2, SYSREF at 20 -> counter 0 at 25, then a 3-beat-off SYSREF
        start(10'd32, 2'd1, 4'd2);
        sysref_at(20);
        run_to(24);
        check_out("os pre", 0, 1'b1, 1);
        run_to(25);
        check_out("os align", 0, 1'b1, 2);
        check("os aligned", 32'(aligned), 32'd1);
        run_to(26);
        check("os next", 32'(lmfc_counter), 32'd1);
        sysref_at(47);
        run_to(51);
        check("os err idle", 32'(sysref_err), 32'd0);
        run_to(52);
        check("os err pulse", 32'(sysref_err), 32'd1);
        check("os err_cnt", 32'(sysref_err_cnt), 32'd1);
        check("os no realign", 32'(lmfc_counter), 32'd3);
        run_to(53);
        check("os err end", 32'(sysref_err), 32'd0);
        check("os state kept", 32'(state), 32'd2);

        // Continuous: M=16, in-phase SYSREF every 16 cycles, then one shifted by 1
        start(10'd64, 2'd2, 4'd0);
        sysref_at(5);
        run_to(8);
        check_out("cont align", 0, 1'b1, 2);
        sysref_at(21);
        sysref_at(37);
        sysref_at(53);
        run_to(69);
        check("cont in-phase cnt", 32'(sysref_err_cnt), 32'd0);
        check("cont in-phase ctr", 32'(lmfc_counter), 32'd13);
        sysref_at(70);
        run_to(73);
        check("cont shift err", 32'(sysref_err), 32'd1);
        check("cont shift cnt", 32'(sysref_err_cnt), 32'd1);
        check("cont realign", 32'(lmfc_counter), 32'd0);
        run_to(74);
        check("cont after", 32'(lmfc_counter), 32'd1);
        sysref_at(86);
        run_to(90);
        check("cont new phase cnt", 32'(sysref_err_cnt), 32'd1);
        check("cont new phase ctr", 32'(lmfc_counter), 32'd1);

        // Saturation (2-bit counter) and re-arm
        start(10'd32, 2'd1, 4'd0);
        sysref_at(5);
        sysref_at(14);
        sysref_at(22);
        run_to(25);
        check("sat cnt2", 32'(sysref_err_cnt), 32'd2);
        sysref_at(30);
        sysref_at(38);
        sysref_at(46);
        run_to(49);
        check("sat err pulse", 32'(sysref_err), 32'd1);
        check("sat cnt held", 32'(sysref_err_cnt), 32'd3);
        run_to(52);
        re_arm = 1'b1;
        tick();
        re_arm = 1'b0;
        check("rearm state", 32'(state), 32'd1);
        check("rearm aligned", 32'(aligned), 32'd0);
        sysref_at(60);
        run_to(62);
        check("rearm wait", 32'(state), 32'd1);
        run_to(63);
        check_out("rearm align", 0, 1'b1, 2);
        check("rearm cnt", 32'(sysref_err_cnt), 32'd3);

        // Multiframe shrink 64 -> 16 octets while counter = 12
        start(10'd64, 2'd0, 4'd0);
        run_to(12);
        check("shrink pre", 32'(lmfc_counter), 32'd12);
        cfg_octets_per_mf = 10'd16;
        run_to(13);
        check_out("shrink wrap", 0, 1'b1, 0);
        run_to(16);
        check_out("shrink p3", 3, 1'b0, 0);
        run_to(17);
        check_out("shrink p4", 0, 1'b1, 0);

        // Reset five cycles after the SYSREF edge with delay 15
        start(10'd32, 2'd1, 4'd15);
        sysref_at(5);
        run_to(11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_out("rst mid", 0, 1'b0, 0);
        check("rst mid aligned", 32'(aligned), 32'd0);
        check("rst mid err_cnt", 32'(sysref_err_cnt), 32'd0);
        run_to(30);
        check_out("rst no align", 2, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
